// File: rtl/axis_packet_tx.sv
// AXI-Stream packet transmitter: loads a whole multi-beat packet in parallel, then streams it beat by beat.
// Optional AXIS_TX_STATS_EN adds packet/beat handshake counters (pkt_count_o, beat_count_o).
package axis_packet_tx_pkg;
  localparam int AXIS_DATA_WIDTH = 32;
  localparam int ID_WIDTH        = 4;
  localparam int DEST_WIDTH      = 4;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic                       tlast;
    logic [ID_WIDTH-1:0]        tid;
    logic [DEST_WIDTH-1:0]      tdest;
  } axis_data_t;

  typedef struct packed {
    logic       tvalid;
    axis_data_t data;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;
endpackage

module axis_packet_tx
  import axis_packet_tx_pkg::*;
#(
  parameter int MAX_BEATS = 8,
  parameter int BEAT_W    = $clog2(MAX_BEATS)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 pkt_valid_i,
  output logic                                 pkt_ready_o,
  input  logic [MAX_BEATS*AXIS_DATA_WIDTH-1:0] pkt_data_i,
  input  logic [BEAT_W-1:0]                    pkt_len_i,
  input  logic [ID_WIDTH-1:0]                  pkt_id_i,
  input  logic [DEST_WIDTH-1:0]                pkt_dest_i,
  output axis_mosi_t                           out_mosi_o,
  input  axis_miso_t                           out_miso_i,
`ifdef AXIS_TX_STATS_EN
  output logic [15:0]                          pkt_count_o,
  output logic [31:0]                          beat_count_o,
`endif
  output logic                                 busy_o
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state_q, state_d;
  logic [MAX_BEATS-1:0][AXIS_DATA_WIDTH-1:0] pkt_beats, pay_q, pay_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d, cnt_nxt, len_q, len_d, len_clamp;
  axis_mosi_t mosi_q, mosi_d;
  logic ready_q, busy_q, hs;

  assign pkt_beats = pkt_data_i;
  assign cnt_nxt   = cnt_q + 1'b1;
  assign hs        = mosi_q.tvalid & out_miso_i.tready;

  // Length field can only overflow the payload when MAX_BEATS is not a power of two.
  generate
    if ((1 << BEAT_W) > MAX_BEATS) begin : g_clamp
      localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(MAX_BEATS - 1);
      assign len_clamp = (pkt_len_i > LAST_IDX) ? LAST_IDX : pkt_len_i;
    end else begin : g_noclamp
      assign len_clamp = pkt_len_i;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    pay_d   = pay_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    mosi_d  = mosi_q;
    case (state_q)
      IDLE: begin
        if (pkt_valid_i) begin
          state_d           = SEND;
          pay_d             = pkt_beats;
          len_d             = len_clamp;
          cnt_d             = '0;
          mosi_d.tvalid     = 1'b1;
          mosi_d.data.tdata = pkt_beats[0];
          mosi_d.data.tlast = (len_clamp == '0);
          mosi_d.data.tid   = pkt_id_i;
          mosi_d.data.tdest = pkt_dest_i;
        end
      end
      SEND: begin
        // Next beat is staged into the output register on the handshake edge.
        if (out_miso_i.tready) begin
          if (cnt_q == len_q) begin
            state_d       = IDLE;
            mosi_d.tvalid = 1'b0;
          end else begin
            cnt_d             = cnt_nxt;
            mosi_d.data.tdata = pay_q[cnt_nxt];
            mosi_d.data.tlast = (cnt_nxt == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pay_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      mosi_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pay_q   <= pay_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      mosi_q  <= mosi_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d == SEND);
    end
  end

  assign out_mosi_o  = mosi_q;
  assign pkt_ready_o = ready_q;
  assign busy_o      = busy_q;

`ifdef AXIS_TX_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [31:0] beat_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else if (hs) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
      if (mosi_q.data.tlast) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_count_o  = pkt_cnt_q;
  assign beat_count_o = beat_cnt_q;
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_axis_packet_tx.sv
// Directed bench for axis_packet_tx: scoreboard of expected beats filled at load, drained by a negedge monitor.
module tb_axis_packet_tx;
  import axis_packet_tx_pkg::*;

  localparam int W  = 32;
  localparam int MB = 8;
  localparam int BW = 3;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             pkt_valid_i;
  logic             pkt_ready_o;
  logic [MB*W-1:0]  pkt_data_i;
  logic [BW-1:0]    pkt_len_i;
  logic [3:0]       pkt_id_i, pkt_dest_i;
  axis_mosi_t       out_mosi_o;
  axis_miso_t       out_miso_i;
  logic             busy_o;
`ifdef AXIS_TX_STATS_EN
  logic [15:0]      pkt_count_o;
  logic [31:0]      beat_count_o;
`endif

  axis_packet_tx #(.MAX_BEATS(MB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .pkt_data_i(pkt_data_i), .pkt_len_i(pkt_len_i),
    .pkt_id_i(pkt_id_i), .pkt_dest_i(pkt_dest_i),
    .out_mosi_o(out_mosi_o), .out_miso_i(out_miso_i),
`ifdef AXIS_TX_STATS_EN
    .pkt_count_o(pkt_count_o), .beat_count_o(beat_count_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  logic [40:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops on handshake, enforces stability while stalled, measures packet gap.
  int          cyc = 0;
  int          last_tlast_cyc = -100;
  int          gap = 0;
  logic        first_beat = 1'b1;
  logic        stall_prev = 1'b0;
  logic [40:0] prev_dat;
  logic [40:0] exp_beat;

  always @(negedge clk_i) begin
    cyc++;
    if (rst_i) begin
      stall_prev = 1'b0;
      first_beat = 1'b1;
    end else begin
      if (stall_prev) begin
        chk("stall_tvalid", 64'(out_mosi_o.tvalid), 64'd1);
        chk("stall_data", 64'(out_mosi_o.data), 64'(prev_dat));
      end
      if (out_mosi_o.tvalid && out_miso_i.tready) begin
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_beat = exp_q.pop_front();
          chk("beat", 64'(out_mosi_o.data), 64'(exp_beat));
        end
        if (first_beat) gap = cyc - last_tlast_cyc;
        first_beat = out_mosi_o.data.tlast;
        if (out_mosi_o.data.tlast) last_tlast_cyc = cyc;
        stall_prev = 1'b0;
      end else begin
        stall_prev = out_mosi_o.tvalid;
        prev_dat   = out_mosi_o.data;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input logic [MB*W-1:0] d, input int len, input logic [3:0] id,
                      input logic [3:0] dest);
    int   n;
    logic acc;
    pkt_valid_i = 1'b1;
    pkt_data_i  = d;
    pkt_len_i   = BW'(len);
    pkt_id_i    = id;
    pkt_dest_i  = dest;
    for (int k = 0; k <= len; k++)
      exp_q.push_back({d[k*W +: W], (k == len), id, dest});
    n = 0;
    do begin
      acc = pkt_ready_o;
      tick();
      n++;
    end while (!acc && n < 200);
    chk("load_accept", 64'(acc), 64'd1);
    pkt_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || out_mosi_o.tvalid) && n < 500) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [MB*W-1:0] ramp(input logic [31:0] base);
    logic [MB*W-1:0] d;
    for (int k = 0; k < MB; k++) d[k*W +: W] = base + 32'(k);
    return d;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MB*W-1:0] d;
    logic [6:0]      pat;

    rst_i = 1'b1; pkt_valid_i = 1'b0; pkt_data_i = '0; pkt_len_i = '0;
    pkt_id_i = '0; pkt_dest_i = '0; out_miso_i.tready = 1'b0;
    tick(); tick();
    chk("rst_tvalid", 64'(out_mosi_o.tvalid), 64'd0);
    chk("rst_ready", 64'(pkt_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_data", 64'(out_mosi_o.data), 64'd0);
    rst_i = 1'b0;
    tick();

    // single-beat packet
    out_miso_i.tready = 1'b1;
    d = '0; d[31:0] = 32'hDEAD_BEEF;
    load(d, 0, 4'd3, 4'd5);
    chk("single_tvalid", 64'(out_mosi_o.tvalid), 64'd1);
    chk("single_tdata", 64'(out_mosi_o.data.tdata), 64'hDEAD_BEEF);
    chk("single_ready_low", 64'(pkt_ready_o), 64'd0);
    chk("single_busy", 64'(busy_o), 64'd1);
    tick();
    chk("single_ready_back", 64'(pkt_ready_o), 64'd1);
    chk("single_tvalid_low", 64'(out_mosi_o.tvalid), 64'd0);
    chk("single_busy_low", 64'(busy_o), 64'd0);
    drain("single");

    // full 8-beat packet; payload input scrambled while sending
    load(ramp(32'h10), 7, 4'd1, 4'd2);
    pkt_data_i = {MB{32'hBAD0_0BAD}};
    drain("full");

    // backpressure pattern 1,0,0,1,0,1,1
    out_miso_i.tready = 1'b0;
    load(ramp(32'hA0), 3, 4'd1, 4'd2);
    pat = 7'b1101001;
    for (int i = 0; i < 7; i++) begin
      out_miso_i.tready = pat[i];
      tick();
    end
    out_miso_i.tready = 1'b1;
    drain("stall");

    // back-to-back loads
    load(ramp(32'h40), 1, 4'd6, 4'd7);
    load(ramp(32'h50), 1, 4'd9, 4'd10);
    drain("b2b");
    chk("b2b_gap", 64'(gap), 64'd2);

    // reset mid-packet
    out_miso_i.tready = 1'b0;
    load(ramp(32'h20), 7, 4'd2, 4'd2);
    tick();
    chk("pre_abort_tvalid", 64'(out_mosi_o.tvalid), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("abort_tvalid", 64'(out_mosi_o.tvalid), 64'd0);
    chk("abort_tlast", 64'(out_mosi_o.data.tlast), 64'd0);
    chk("abort_busy", 64'(busy_o), 64'd0);
    exp_q.delete();
    tick();
    rst_i = 1'b0;
    tick();
    out_miso_i.tready = 1'b1;
    load(ramp(32'h30), 1, 4'd4, 4'd4);
    drain("post_abort");

`ifdef AXIS_TX_STATS_EN
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    chk("stats_rst_pkt", 64'(pkt_count_o), 64'd0);
    load(ramp(32'h100), 0, 4'd1, 4'd1);
    load(ramp(32'h200), 3, 4'd2, 4'd2);
    load(ramp(32'h300), 7, 4'd3, 4'd3);
    drain("stats");
    chk("stats_pkt", 64'(pkt_count_o), 64'd3);
    chk("stats_beat", 64'(beat_count_o), 64'd13);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
